sb_pkt_fifo: RTL
================

Name: sb_pkt_fifo

Overview:
- Synthesizable elastic buffer that consumes the switchboard stream produced by the queue-to-switchboard simulation source.
- Stream fields: data, dest, last, valid/ready.
- Re-presents the stream to downstream logic with full decoupling: registered in_ready, no combinational ready/valid path across the block.
- Sits directly downstream of the queue-to-switchboard source in testbenches and DUT wrappers; absorbs the bursty valid patterns (alternating / continuous / random) that source generates.

Parameters:
- DW, 416, payload width in bits; matches the switchboard stream data width.
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk  input  1  clock
- nreset  input  1  synchronous, active-low reset
- in_data  input  DW  upstream payload
- in_dest  input  32  upstream destination
- in_last  input  1  upstream end-of-packet marker
- in_valid  input  1  upstream valid
- in_ready  output  1  upstream ready; registered, equals !full
- out_data  output  DW  downstream payload
- out_dest  output  32  downstream destination
- out_last  output  1  downstream end-of-packet marker
- out_valid  output  1  downstream valid
- out_ready  input  1  downstream ready
- count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-low, port nreset.
- Reset (nreset=0 at posedge):
  - wr_ptr = rd_ptr = 0, count = 0.
  - out_valid = 0, in_ready = 0 during reset; in_ready = 1 on the first cycle after reset release.
  - Storage array contents are not reset. out_data, out_dest and out_last are don't-care while out_valid = 0.
- Push: in_valid && in_ready at posedge. Entry {data, dest, last} written at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
- Pop: out_valid && out_ready at posedge; rd_ptr wraps DEPTH-1 -> 0.
- Pointers are $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - full: low bits equal, MSBs differ.
  - empty: pointers equal.
- Latency: a word pushed into an empty FIFO appears on out_valid in the next cycle (1-cycle latency). There is no same-cycle bypass.
- out_data, out_dest, out_last are read from the entry at rd_ptr. They are stable while out_valid && !out_ready.
- count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- in_ready = !full, derived from registered count/pointers, so it does not depend on out_ready in the same cycle.
- Simultaneous events:
  - When full, a same-cycle pop does not enable a push (in_ready is already low). Throughput at full is one word every other cycle until occupancy drops.
  - When not full and not empty, push and pop in the same cycle leave count unchanged.
- Upstream may drop in_valid without a handshake; nothing is written.
- Downstream stalls indefinitely: data is held, no loss, no duplication.
- Reset mid-operation: all buffered words are discarded. out_valid is low in the cycle after reset asserts.
- Assertions (simulation only):
  - no push when full
  - count <= DEPTH
  - out_* stable while stalled

Optional Feature:
- Macro: SB_PKT_FIFO_STORE_FWD_EN.
- Defined (store-and-forward mode):
  - A pkt_count register counts buffered words with last=1: +1 on push with in_last, -1 on pop with out_last.
  - out_valid = !empty && (pkt_count != 0 || full).
  - The full override is a cut-through fallback so packets longer than DEPTH cannot deadlock.
  - Reset clears pkt_count.
- Undefined (cut-through mode): out_valid = !empty; no pkt_count logic is generated.

Decomposition:
- Package sb_pkt_fifo_pkg holds:
  - typedef sb_entry_t: packed struct {last, dest[31:0], data[DW-1:0]}; DW is supplied via parameterised width localparams.
  - localparam SB_DEST_W = 32.
  - function for pointer width from DEPTH.
- One sub-module, sb_pkt_fifo_mem: a DEPTH x entry register array with a synchronous write port and an asynchronous read port.
- Pointer, count and packet logic stay in the top level.

Test Plan:
- Reset, then push 1 word (data=0x1234, dest=0x5, last=1) -> out_valid rises exactly 1 cycle later; fields match; count goes 1 then 0 after pop.
- out_ready=0, push 4 words (DEPTH=4) -> in_ready=0 after the 4th push, count=4. Then out_ready=1 -> words come out in order 0..3; in_ready returns 1 the cycle after the first pop.
- Continuous in_valid=1 and out_ready=1 for 100 words -> after a 1-cycle fill, one word out per cycle; count stays 1; no gaps.
- Random in_valid/out_ready (seeded) over 10k words -> scoreboard shows an exact ordered match of data/dest/last.
- Assert nreset=0 with 3 words buffered -> next cycle out_valid=0, count=0; later pushes come out alone, with no stale words.
- With SB_PKT_FIFO_STORE_FWD_EN:
  - Push 2 words with last=0 -> out_valid stays 0. Push a 3rd word with last=1 -> out_valid=1 the next cycle.
  - Push 4 words, none with last=1 -> FIFO is full and out_valid=1 (fallback).

Source files
------------

// File: rtl/sb_pkt_fifo_pkg.sv
// Shared entry layout and sizing helpers for the switchboard packet FIFO.
package sb_pkt_fifo_pkg;

   localparam int SB_DW      = 416;
   localparam int SB_DEST_W  = 32;
   localparam int SB_ENTRY_W = 1 + SB_DEST_W + SB_DW;

   typedef struct packed {
      logic                 last;
      logic [SB_DEST_W-1:0] dest;
      logic [SB_DW-1:0]     data;
   } sb_entry_t;

   // One extra MSB over the address lets full and empty be told apart.
   function automatic int sb_ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int sb_entry_w(input int dw);
      return 1 + SB_DEST_W + dw;
   endfunction

endpackage

// File: rtl/sb_pkt_fifo_mem.sv
// DEPTH x W register array: synchronous write, asynchronous read, no reset.
module sb_pkt_fifo_mem
   import sb_pkt_fifo_pkg::*;
#(
   parameter int W     = SB_ENTRY_W,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH)-1:0]   waddr_i,
   input  logic [W-1:0]               wdata_i,
   input  logic [$clog2(DEPTH)-1:0]   raddr_i,
   output logic [W-1:0]               rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sb_pkt_fifo.sv
// Elastic buffer for the switchboard stream; 1-cycle latency, no bypass path.
// in_ready is registered (!full) and never depends on out_ready in the same cycle.
// SB_PKT_FIFO_STORE_FWD_EN holds out_valid until a whole packet is buffered.
module sb_pkt_fifo
   import sb_pkt_fifo_pkg::*;
#(
   parameter int DW    = SB_DW,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         nreset,
   input  logic [DW-1:0]                in_data,
   input  logic [SB_DEST_W-1:0]         in_dest,
   input  logic                         in_last,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DW-1:0]                out_data,
   output logic [SB_DEST_W-1:0]         out_dest,
   output logic                         out_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = sb_ptr_w(DEPTH);
   localparam int AW = PW - 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = sb_entry_w(DW);

   typedef struct packed {
      logic                 last;
      logic [SB_DEST_W-1:0] dest;
      logic [DW-1:0]        data;
   } entry_t;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          in_ready_q, in_ready_d;
   logic          push, pop, empty, full;
   entry_t        wr_entry, rd_entry;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign push  = in_valid && in_ready_q;
   assign pop   = out_valid && out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Ready is computed from next-state pointers so it can be registered.
      in_ready_d = !((wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]));
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign wr_entry = {in_last, in_dest, in_data};

   sb_pkt_fifo_mem #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rd_entry)
   );

`ifdef SB_PKT_FIFO_STORE_FWD_EN
   logic [CW-1:0] pkt_count_q, pkt_count_d;
   logic          push_eop, pop_eop;

   assign push_eop = push && in_last;
   assign pop_eop  = pop && rd_entry.last;

   always_comb begin
      pkt_count_d = pkt_count_q;
      if (push_eop && !pop_eop) begin
         pkt_count_d = pkt_count_q + CW'(1);
      end else if (pop_eop && !push_eop) begin
         pkt_count_d = pkt_count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         pkt_count_q <= '0;
      end else begin
         pkt_count_q <= pkt_count_d;
      end
   end

   // Full overrides the packet gate so packets longer than DEPTH still drain.
   assign out_valid = !empty && ((pkt_count_q != '0) || full);
`else
   assign out_valid = !empty;
`endif

   assign in_ready = in_ready_q;
   assign count    = count_q;
   assign out_data = rd_entry.data;
   assign out_dest = rd_entry.dest;
   assign out_last = rd_entry.last;

`ifndef SYNTHESIS
   a_no_push_full: assert property (@(posedge clk) disable iff (!nreset) !(push && full));
   a_count_max:    assert property (@(posedge clk) disable iff (!nreset) count_q <= CW'(DEPTH));
   a_stall_stable: assert property (@(posedge clk) disable iff (!nreset)
      (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_dest) && $stable(out_last)));
`endif

endmodule
